sspis_if: RTL and testbench

SPI slave (target) byte engine: the responder counterpart of the SPI master interface in the sspim subsystem. It samples an external SCK/SSN/MOSI from the pads into the system clock domain, deserialises received bytes, and serialises transmit bytes onto MISO. It supports all four CPOL/CPHA modes, MSB-first. It sits between the pad ring and a register/FIFO front-end that supplies `tx_byte` and consumes `rx_byte`.

---
 rtl/sspis_pkg.sv | 9 +
 rtl/sspis_sync.sv | 21 ++
 rtl/sspis_if.sv | 121 ++++++++++++
 tb/tb_sspis_if.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sspis_pkg.sv
// sspis_pkg: shared types and constants for the SPI slave byte engine.
package sspis_pkg;

    typedef enum logic {SSPIS_IDLE, SSPIS_SHIFT} sspis_state_e;

    localparam logic [7:0] SSPIS_FILL_BYTE = 8'hFF;
    localparam int         SSPIS_CNT_W     = 3;

endpackage

// File: rtl/sspis_sync.sv
// sspis_sync: STAGES-deep flop chain that brings an asynchronous pad signal into clk.
module sspis_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= {STAGES{RST_VAL}};
        else          sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/sspis_if.sv
// sspis_if: SPI slave byte engine, all CPOL/CPHA modes, MSB first, one-byte tx holding buffer.
// Define SSPIS_UNDERRUN_EN to add the tx_underrun pulse output.
module sspis_if
    import sspis_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cfg_cpol,
    input  logic       cfg_cpha,
    input  logic       sck,
    input  logic       ssn,
    input  logic       sdin,
    output logic       sdout,
    output logic       sdout_oen,
    input  logic [7:0] tx_byte,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       busy
`ifdef SSPIS_UNDERRUN_EN
    ,
    output logic       tx_underrun
`endif
);

    logic sck_s, ssn_s, sdin_s;
    logic sck_p_q, ssn_p_q;
    sspis_state_e state_q;
    logic [SSPIS_CNT_W-1:0] bit_cnt_q;
    logic [6:0] rx_sreg_q;
    logic [7:0] rx_byte_q, tx_sreg_q, buf_q, buf_d, load_byte;
    logic rx_valid_q, buf_full_q, buf_full_d;
    logic ssn_fall, ssn_rise, sck_rise, sck_fall, lead, trail, sample_e, shift_e, load;

    sspis_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk(clk), .reset_n(reset_n), .d_i(sck), .q_o(sck_s)
    );
    sspis_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ssn (
        .clk(clk), .reset_n(reset_n), .d_i(ssn), .q_o(ssn_s)
    );
    sspis_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdin (
        .clk(clk), .reset_n(reset_n), .d_i(sdin), .q_o(sdin_s)
    );

    always_comb begin
        ssn_fall   = ssn_p_q & ~ssn_s;
        ssn_rise   = ~ssn_p_q & ssn_s;
        sck_rise   = sck_s & ~sck_p_q;
        sck_fall   = ~sck_s & sck_p_q;
        lead       = cfg_cpol ? sck_fall : sck_rise;
        trail      = cfg_cpol ? sck_rise : sck_fall;
        sample_e   = (state_q == SSPIS_SHIFT) & ~ssn_rise & (cfg_cpha ? trail : lead);
        shift_e    = (state_q == SSPIS_SHIFT) & ~ssn_rise & (cfg_cpha ? lead : trail);
        // CPHA=0 must present bit 7 before the first sample edge, so ssn falling also loads
        load       = (shift_e & (bit_cnt_q == '0)) | ((state_q == SSPIS_IDLE) & ssn_fall & ~cfg_cpha);
        load_byte  = buf_full_q ? buf_q : SSPIS_FILL_BYTE;
        buf_full_d = (buf_full_q & ~load) | (tx_valid & ~buf_full_q);
        buf_d      = (tx_valid & ~buf_full_q) ? tx_byte : buf_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_p_q    <= 1'b0;
            ssn_p_q    <= 1'b1;
            state_q    <= SSPIS_IDLE;
            bit_cnt_q  <= '0;
            rx_sreg_q  <= '0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_sreg_q  <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
        end else begin
            sck_p_q    <= sck_s;
            ssn_p_q    <= ssn_s;
            rx_valid_q <= 1'b0;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            if (state_q == SSPIS_IDLE) begin
                if (ssn_fall) begin
                    state_q   <= SSPIS_SHIFT;
                    bit_cnt_q <= '0;
                end
            end else if (ssn_rise) begin
                state_q   <= SSPIS_IDLE;
                bit_cnt_q <= '0;
            end else if (sample_e) begin
                rx_sreg_q <= {rx_sreg_q[5:0], sdin_s};
                bit_cnt_q <= bit_cnt_q + 1'b1;
                if (bit_cnt_q == {SSPIS_CNT_W{1'b1}}) begin
                    rx_byte_q  <= {rx_sreg_q, sdin_s};
                    rx_valid_q <= 1'b1;
                end
            end
            if (load)         tx_sreg_q <= load_byte;
            else if (shift_e) tx_sreg_q <= {tx_sreg_q[6:0], 1'b0};
        end
    end

`ifdef SSPIS_UNDERRUN_EN
    logic tx_underrun_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) tx_underrun_q <= 1'b0;
        else          tx_underrun_q <= load & ~buf_full_q;
    end

    assign tx_underrun = tx_underrun_q;
`endif

    assign sdout     = tx_sreg_q[7];
    assign sdout_oen = ssn_s;
    assign busy      = ~ssn_s;
    assign tx_ready  = ~buf_full_q;
    assign rx_byte   = rx_byte_q;
    assign rx_valid  = rx_valid_q;

endmodule

// File: tb/tb_sspis_if.sv
// tb_sspis_if: SPI master model driving sspis_if, with rx scoreboard and MISO/holding-buffer reference model.
module tb_sspis_if;

    logic clk = 1'b0, reset_n = 1'b0, cfg_cpol = 1'b0, cfg_cpha = 1'b0;
    logic sck = 1'b0, ssn = 1'b1, sdin = 1'b0, tx_valid = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic sdout, sdout_oen, tx_ready, rx_valid, busy;
    logic [7:0] rx_byte;
`ifdef SSPIS_UNDERRUN_EN
    logic tx_underrun;
`endif

    sspis_if #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
        .sck(sck), .ssn(ssn), .sdin(sdin), .sdout(sdout), .sdout_oen(sdout_oen),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .busy(busy)
`ifdef SSPIS_UNDERRUN_EN
        , .tx_underrun(tx_underrun)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    int exp_under = 0, got_under = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] mosi[$];
    logic [7:0] refill[$];
    logic mdl_full = 1'b0;
    logic [7:0] mdl_buf = 8'h00, cur_tx = 8'h00;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: every rx_valid pulse consumes one expected byte
    always @(negedge clk) begin
        if (reset_n && rx_valid) begin
            if (exp_rx.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_extra: got %h expected no rx_valid", rx_byte);
            end else check("rx_byte", rx_byte, exp_rx.pop_front());
        end
`ifdef SSPIS_UNDERRUN_EN
        if (reset_n && tx_underrun) got_under++;
`endif
    end

    // A byte load takes the buffered byte if any, else the fill byte
    task automatic model_load();
        cur_tx = mdl_full ? mdl_buf : 8'hFF;
        if (!mdl_full) exp_under++;
        mdl_full = 1'b0;
    endtask

    task automatic half(input bit ld);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (ld && c == 5 && refill.size() > 0) begin
                check("tx_ready_after_load", 8'(tx_ready), 8'd1);
                tx_byte  = refill.pop_front();
                tx_valid = 1'b1;
                mdl_full = 1'b1;
                mdl_buf  = tx_byte;
            end else if (tx_valid) begin
                tx_valid = 1'b0;
                check("tx_ready_after_write", 8'(tx_ready), 8'd0);
            end
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        @(negedge clk);
        check("tx_ready_idle", 8'(tx_ready), 8'(!mdl_full));
        tx_byte  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("tx_ready_full", 8'(tx_ready), 8'd0);
        mdl_full = 1'b1;
        mdl_buf  = b;
    endtask

    task automatic xfer(input bit cpol, input bit cpha, input int last_bits, input bit keep_ssn);
        int n, nb;
        logic [7:0] got, exp_tx;
        n = mosi.size();
        got = 8'h00;
        exp_tx = 8'h00;
        cfg_cpol = cpol;
        cfg_cpha = cpha;
        sck = cpol;
        repeat (8) @(negedge clk);
        if (!cpha) begin
            sdin = mosi[0][7];
            ssn = 1'b0;
            model_load();
            half(1'b1);
        end else begin
            ssn = 1'b0;
            half(1'b0);
        end
        check("busy_active", 8'(busy), 8'd1);
        check("oen_active", 8'(sdout_oen), 8'd0);
        for (int k = 0; k < n; k++) begin
            nb = (k == n - 1) ? last_bits : 8;
            if (nb == 8) exp_rx.push_back(mosi[k]);
            for (int i = 7; i >= 8 - nb; i--) begin
                sck = ~cpol;
                if (cpha) begin
                    sdin = mosi[k][i];
                    if (i == 7) model_load();
                end else got[i] = sdout;
                if (i == 7) exp_tx = cur_tx;
                half(cpha && i == 7);
                sck = cpol;
                if (cpha) got[i] = sdout;
                else if (i > 0) sdin = mosi[k][i-1];
                else begin
                    if (k < n - 1) sdin = mosi[k+1][7];
                    model_load();
                end
                half(!cpha && i == 0);
            end
            if (nb == 8) check("miso", got, exp_tx);
        end
        if (!keep_ssn) begin
            ssn = 1'b1;
            repeat (8) @(negedge clk);
            check("busy_idle", 8'(busy), 8'd0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_sdout", 8'(sdout), 8'd0);
        check("rst_oen", 8'(sdout_oen), 8'd1);
        check("rst_tx_ready", 8'(tx_ready), 8'd1);
        check("rst_rx_byte", rx_byte, 8'h00);
        check("rst_rx_valid", 8'(rx_valid), 8'd0);
        check("rst_busy", 8'(busy), 8'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        write_byte(8'h3C);
        mosi = '{8'hA5};
        xfer(1'b0, 1'b0, 8, 1'b0);

        for (int m = 0; m < 4; m++) begin
            write_byte(8'h10 + 8'(m));
            refill = '{8'hC0 + 8'(m)};
            mosi = '{8'h81, 8'h7E};
            xfer(m[1], m[0], 8, 1'b0);
        end

        mosi = '{8'h6B};
        xfer(1'b1, 1'b1, 8, 1'b0);

        write_byte(8'h21);
        refill = '{8'h34, 8'h56};
        mosi = '{8'h12, 8'hF0};
        xfer(1'b0, 1'b1, 5, 1'b0);
        mosi = '{8'h55};
        xfer(1'b0, 1'b1, 8, 1'b0);

        mosi = '{8'h99};
        xfer(1'b1, 1'b0, 4, 1'b1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid_rst_sdout", 8'(sdout), 8'd0);
        check("mid_rst_oen", 8'(sdout_oen), 8'd1);
        check("mid_rst_tx_ready", 8'(tx_ready), 8'd1);
        check("mid_rst_rx_byte", rx_byte, 8'h00);
        check("mid_rst_rx_valid", 8'(rx_valid), 8'd0);
        check("mid_rst_busy", 8'(busy), 8'd0);
        mdl_full = 1'b0;
        ssn = 1'b1;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        write_byte(8'h9E);
        mosi = '{8'hC3};
        xfer(1'b1, 1'b0, 8, 1'b0);

        for (int r = 0; r < 8; r++) begin
            int n;
            n = int'($urandom_range(1, 3));
            mosi.delete();
            refill.delete();
            for (int j = 0; j < n; j++) mosi.push_back(8'($urandom));
            if (!mdl_full && $urandom_range(0, 3) != 0) write_byte(8'($urandom));
            for (int j = 0; j < int'($urandom_range(0, n)); j++) refill.push_back(8'($urandom));
            xfer(1'($urandom), 1'($urandom), 8, 1'b0);
        end

        repeat (10) @(negedge clk);
        check("rx_queue_drained", 8'(exp_rx.size()), 8'd0);
`ifdef SSPIS_UNDERRUN_EN
        check("underrun_count", 8'(got_under), 8'(exp_under));
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule
